// File: rtl/wdt_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_ctrl_if
//  Description : CPU I/O bus bundle for the watchdog controller.
//                Master side (CPU / address decoder) drives the chip
//                select, register offset, read/write strobes and write
//                data. Slave side (wdt_ctrl) returns registered read data.
//  Signals     : cs, addr[1:0], wr_en, rd_en, wdata[15:0]  (master -> slave)
//                rdata[15:0]                               (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface wdt_ctrl_if;
    logic        cs;
    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (
        output cs,
        output addr,
        output wr_en,
        output rd_en,
        output wdata,
        input  rdata
    );

    modport slave (
        input  cs,
        input  addr,
        input  wr_en,
        input  rd_en,
        input  wdata,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/wdt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_ctrl
//  Description : Memory-mapped system watchdog controller. Software enables
//                the watchdog, programs timeout and prescaler, kicks it with
//                a key and can lock its configuration. The first expiry
//                raises an early-warning interrupt; the second drives a CPU
//                reset pulse of programmable length.
//  Ports       : clock          - system clock, rising edge
//                reset_n        - asynchronous active-low reset
//                bus            - CPU I/O bus (slave modport of wdt_ctrl_if)
//                wdt_irq        - early-warning interrupt (level, registered)
//                wdt_reset_out  - CPU reset request, high PL+1 cycles
//  Registers   : 0 CTRL   [0] EN, [1] LOCK, [3:2] PS, [6:4] PL
//                1 RELOAD timeout in prescaled ticks
//                2 KICK (write) / STATUS (read) [1:0] state, [2] irq,
//                                               [3] TO, [4] BK
//                3 COUNT  current down-counter value (read-only)
//  Revision    : 1.0  initial release
// ============================================================================
module wdt_ctrl #(
    parameter logic [15:0] KICK_KEY   = 16'h5A5A,
    parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
    input  wire logic   clock,
    input  wire logic   reset_n,
    wdt_ctrl_if.slave   bus,
    output logic        wdt_irq,
    output logic        wdt_reset_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WARN  = 2'd2,
        ST_PULSE = 2'd3
    } state_t;

    state_t      state_q,   state_d;
    logic        en_q,      en_d;
    logic        lock_q,    lock_d;
    logic [1:0]  ps_q,      ps_d;
    logic [2:0]  pl_q,      pl_d;
    logic [15:0] reload_q,  reload_d;
    logic [15:0] count_q,   count_d;
    logic [11:0] presc_q,   presc_d;
    logic [2:0]  pulse_q,   pulse_d;
    logic        irq_q,     irq_d;
    logic        rstout_q,  rstout_d;
    logic        to_q,      to_d;
    logic        bk_q,      bk_d;
    logic [15:0] rdata_q,   rdata_d;

    logic        wr_s;
    logic        rd_s;
    logic        active_s;
    logic        tick_s;
    logic        wr_ok_s;
    logic        ctrl_wr_s;
    logic        reload_wr_s;
    logic        kick_wr_s;
    logic [11:0] div_max_s;
    logic [15:0] reload_val_s;

    assign wr_s     = bus.cs & bus.wr_en;
    assign rd_s     = bus.cs & bus.rd_en;
    assign active_s = (state_q == ST_RUN) || (state_q == ST_WARN);

    // Terminal count of the prescaler for divide-by 1/16/256/4096.
    always_comb begin
        div_max_s = 12'd0;
        case (ps_q)
            2'd0:    div_max_s = 12'd0;
            2'd1:    div_max_s = 12'd15;
            2'd2:    div_max_s = 12'd255;
            default: div_max_s = 12'd4095;
        endcase
    end

    assign tick_s       = active_s && (presc_q == div_max_s);
    // A zero timeout would never expire, so it is treated as one tick.
    assign reload_val_s = (reload_q == 16'd0) ? 16'd1 : reload_q;

    // Every bus write is dropped while the CPU reset pulse is active.
    assign wr_ok_s     = wr_s && (state_q != ST_PULSE);
    assign ctrl_wr_s   = wr_ok_s && (bus.addr == 2'd0) && !lock_q;
    assign reload_wr_s = wr_ok_s && (bus.addr == 2'd1) && !lock_q;
    assign kick_wr_s   = wr_ok_s && (bus.addr == 2'd2) && active_s;

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        lock_d   = lock_q;
        ps_d     = ps_q;
        pl_d     = pl_q;
        reload_d = reload_q;
        count_d  = count_q;
        pulse_d  = pulse_q;
        irq_d    = irq_q;
        rstout_d = rstout_q;
        to_d     = to_q;
        bk_d     = bk_q;
        rdata_d  = rdata_q;

        // Prescaler free-runs only while the timeout counter is live.
        if (active_s) begin
            presc_d = tick_s ? 12'd0 : presc_q + 12'd1;
        end else begin
            presc_d = 12'd0;
        end

        if (ctrl_wr_s) begin
            en_d   = bus.wdata[0];
            lock_d = bus.wdata[1];
            ps_d   = bus.wdata[3:2];
            pl_d   = bus.wdata[6:4];
        end
        if (reload_wr_s) begin
            reload_d = bus.wdata;
        end

        // Bus-initiated transitions take precedence over a same-cycle tick,
        // so a valid kick always beats an expiry and a bad kick enters
        // PULSE exactly once.
        if (ctrl_wr_s && !bus.wdata[0]) begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
            presc_d = 12'd0;
        end else if (ctrl_wr_s && bus.wdata[0] && !en_q) begin
            state_d = ST_RUN;
            count_d = reload_val_s;
            presc_d = 12'd0;
            irq_d   = 1'b0;
        end else if (kick_wr_s) begin
            presc_d = 12'd0;
            if (bus.wdata == KICK_KEY) begin
                state_d = ST_RUN;
                count_d = reload_val_s;
                irq_d   = 1'b0;
            end else begin
                state_d  = ST_PULSE;
                bk_d     = 1'b1;
                pulse_d  = pl_q;
                rstout_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tick_s) begin
                        if (count_q <= 16'd1) begin
                            state_d = ST_WARN;
                            irq_d   = 1'b1;
                            count_d = reload_val_s;
                        end else begin
                            count_d = count_q - 16'd1;
                        end
                    end
                end
                ST_WARN: begin
                    if (tick_s) begin
                        if (count_q <= 16'd1) begin
                            state_d  = ST_PULSE;
                            to_d     = 1'b1;
                            pulse_d  = pl_q;
                            rstout_d = 1'b1;
                            count_d  = 16'd0;
                        end else begin
                            count_d = count_q - 16'd1;
                        end
                    end
                end
                ST_PULSE: begin
                    // Pulse counter holds PL on entry, so the output stays
                    // high for PL+1 cycles before the zero check releases it.
                    if (pulse_q == 3'd0) begin
                        state_d  = ST_RUN;
                        count_d  = reload_val_s;
                        presc_d  = 12'd0;
                        irq_d    = 1'b0;
                        rstout_d = 1'b0;
                    end else begin
                        pulse_d = pulse_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end

        if (rd_s) begin
            case (bus.addr)
                2'd0:    rdata_d = {9'd0, pl_q, ps_q, lock_q, en_q};
                2'd1:    rdata_d = reload_q;
                2'd2:    rdata_d = {11'd0, bk_q, to_q, irq_q, state_q};
                default: rdata_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            lock_q   <= 1'b0;
            ps_q     <= 2'd0;
            pl_q     <= 3'd0;
            reload_q <= RELOAD_RST;
            count_q  <= RELOAD_RST;
            presc_q  <= 12'd0;
            pulse_q  <= 3'd0;
            irq_q    <= 1'b0;
            rstout_q <= 1'b0;
            to_q     <= 1'b0;
            bk_q     <= 1'b0;
            rdata_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            lock_q   <= lock_d;
            ps_q     <= ps_d;
            pl_q     <= pl_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            pulse_q  <= pulse_d;
            irq_q    <= irq_d;
            rstout_q <= rstout_d;
            to_q     <= to_d;
            bk_q     <= bk_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign wdt_irq       = irq_q;
    assign wdt_reset_out = rstout_q;

endmodule
`default_nettype wire

// File: tb/tb_wdt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wdt_ctrl
//  Description : Directed self-checking bench for wdt_ctrl. Bus operations
//                start and end on a falling clock edge; outputs are sampled
//                on falling edges, away from the active rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wdt_ctrl;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_RELOAD = 2'd1;
    localparam logic [1:0] A_KICK   = 2'd2;
    localparam logic [1:0] A_COUNT  = 2'd3;

    logic clock;
    logic reset_n;
    logic wdt_irq;
    logic wdt_reset_out;

    int tests_run    = 0;
    int tests_failed = 0;

    wdt_ctrl_if u_if ();

    wdt_ctrl #(
        .KICK_KEY   (16'h5A5A),
        .RELOAD_RST (16'hFFFF)
    ) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (u_if.slave),
        .wdt_irq       (wdt_irq),
        .wdt_reset_out (wdt_reset_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        u_if.cs    = 1'b1;
        u_if.wr_en = 1'b1;
        u_if.addr  = a;
        u_if.wdata = d;
        @(negedge clock);
        u_if.cs    = 1'b0;
        u_if.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        u_if.cs    = 1'b1;
        u_if.rd_en = 1'b1;
        u_if.addr  = a;
        @(negedge clock);
        u_if.cs    = 1'b0;
        u_if.rd_en = 1'b0;
        d = u_if.rdata;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        u_if.cs    = 1'b0;
        u_if.wr_en = 1'b0;
        u_if.rd_en = 1'b0;
        u_if.addr  = 2'd0;
        u_if.wdata = 16'd0;
        wait_cyc(3);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic [15:0] rd;
        int          k;
        logic        saw_bad;

        // ---------------- reset defaults ----------------
        do_reset();
        check_eq("rst_irq",    {15'd0, wdt_irq},       16'd0);
        check_eq("rst_rstout", {15'd0, wdt_reset_out}, 16'd0);
        bus_read(A_COUNT, rd);  check_eq("rst_count",  rd, 16'hFFFF);
        bus_read(A_KICK, rd);   check_eq("rst_status", rd, 16'h0000);
        bus_read(A_CTRL, rd);   check_eq("rst_ctrl",   rd, 16'h0000);
        bus_read(A_RELOAD, rd); check_eq("rst_reload", rd, 16'hFFFF);

        // ---------------- early warning then reset pulse ----------------
        do_reset();
        bus_write(A_RELOAD, 16'd4);
        bus_write(A_CTRL, 16'h0001);             // enable edge E
        wait_cyc(3);                             // E+3
        check_eq("exp_irq_early", {15'd0, wdt_irq}, 16'd0);
        wait_cyc(1);                             // E+4
        check_eq("exp_irq_rise", {15'd0, wdt_irq}, 16'd1);
        check_eq("exp_rst_low",  {15'd0, wdt_reset_out}, 16'd0);
        wait_cyc(3);                             // E+7
        check_eq("exp_rst_early", {15'd0, wdt_reset_out}, 16'd0);
        wait_cyc(1);                             // E+8
        check_eq("exp_rst_high", {15'd0, wdt_reset_out}, 16'd1);
        wait_cyc(1);                             // E+9
        check_eq("exp_rst_drop", {15'd0, wdt_reset_out}, 16'd0);
        bus_read(A_KICK, rd);
        check_eq("exp_status", rd, 16'h0009);    // RUN, TO=1

        // ---------------- valid kick in WARN, periodic kicks ----------------
        do_reset();
        bus_write(A_RELOAD, 16'd8);
        bus_write(A_CTRL, 16'h0005);             // EN, PS=1 (/16)
        k = 0;
        while (!wdt_irq && k < 200) begin
            @(negedge clock);
            k++;
        end
        check_eq("kick_irq_latency", k[15:0], 16'd128);
        bus_write(A_KICK, 16'h5A5A);
        check_eq("kick_irq_clear", {15'd0, wdt_irq}, 16'd0);
        bus_read(A_KICK, rd);  check_eq("kick_status", rd, 16'h0001);
        bus_read(A_COUNT, rd); check_eq("kick_count",  rd, 16'd8);
        saw_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 100; c++) begin
                @(negedge clock);
                if (wdt_irq || wdt_reset_out) saw_bad = 1'b1;
            end
            bus_write(A_KICK, 16'h5A5A);
        end
        check_eq("kick_no_expire", {15'd0, saw_bad}, 16'd0);
        bus_read(A_KICK, rd);  check_eq("kick_status_end", rd, 16'h0001);

        // ---------------- bad key, writes ignored during PULSE ----------------
        do_reset();
        bus_write(A_RELOAD, 16'd100);
        bus_write(A_CTRL, 16'h0031);             // EN, PL=3
        bus_write(A_KICK, 16'h1234);
        check_eq("bk_rst_first", {15'd0, wdt_reset_out}, 16'd1);
        bus_write(A_CTRL, 16'h0000);             // must be ignored
        k = 0;
        while (wdt_reset_out && k < 20) begin
            @(negedge clock);
            k++;
        end
        check_eq("bk_rst_remaining", k[15:0], 16'd3);
        check_eq("bk_irq", {15'd0, wdt_irq}, 16'd0);
        bus_read(A_KICK, rd);  check_eq("bk_status", rd, 16'h0011);   // RUN, BK=1, TO=0
        bus_read(A_CTRL, rd);  check_eq("bk_ctrl",   rd, 16'h0031);

        // ---------------- lock ----------------
        do_reset();
        bus_write(A_CTRL, 16'h0003);
        bus_write(A_CTRL, 16'h0000);
        bus_write(A_RELOAD, 16'd2);
        bus_read(A_CTRL, rd);   check_eq("lock_ctrl",   rd, 16'h0003);
        bus_read(A_RELOAD, rd); check_eq("lock_reload", rd, 16'hFFFF);
        bus_read(A_KICK, rd);   check_eq("lock_status", rd, 16'h0001);
        do_reset();
        bus_read(A_CTRL, rd);   check_eq("lock_cleared", rd, 16'h0000);
        bus_write(A_CTRL, 16'h0001);
        bus_write(A_CTRL, 16'h0000);
        bus_read(A_KICK, rd);   check_eq("unlock_idle", rd, 16'h0000);

        // ---------------- kick / expiry race in WARN ----------------
        do_reset();
        bus_write(A_RELOAD, 16'd4);
        bus_write(A_CTRL, 16'h0001);             // enable edge E, irq at E+4
        wait_cyc(7);                             // E+7: WARN, count==1, tick pending
        check_eq("race_irq_pre", {15'd0, wdt_irq}, 16'd1);
        bus_write(A_KICK, 16'h5A5A);             // lands on the expiring tick
        check_eq("race_irq_post", {15'd0, wdt_irq}, 16'd0);
        check_eq("race_no_pulse", {15'd0, wdt_reset_out}, 16'd0);
        bus_read(A_COUNT, rd);  check_eq("race_count",  rd, 16'd4);
        bus_read(A_KICK, rd);   check_eq("race_status", rd, 16'h0001);

        // ---------------- asynchronous reset mid-PULSE ----------------
        do_reset();
        bus_write(A_RELOAD, 16'd100);
        bus_write(A_CTRL, 16'h0071);             // EN, PL=7
        bus_write(A_KICK, 16'h0000);
        check_eq("areset_pulse_high", {15'd0, wdt_reset_out}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;                                      // still before the next rising edge
        check_eq("areset_pulse_drop", {15'd0, wdt_reset_out}, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wdt_ctrl.md
# wdt_ctrl

Memory-mapped controller for the system watchdog. It sits on the CPU I/O bus and lets software enable the watchdog, set its timeout and prescaler, kick it with a key, and lock its configuration. Expiry is two-stage: the first expiry raises an early-warning interrupt, and the second drives a CPU reset pulse of programmable length. It replaces direct write-strobe kicking with a configurable, key-protected timer.

## Interface
Parameters:
- KICK_KEY, 16'h5A5A, value that must be written to the KICK register to reload the counter.
- RELOAD_RST, 16'hFFFF, reset value of the RELOAD register.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  chip select from the I/O address decoder.
- addr  in  2  register offset: 0 CTRL, 1 RELOAD, 2 KICK (write) / STATUS (read), 3 COUNT (read-only).
- wr_en  in  1  write strobe; qualified by cs.
- rd_en  in  1  read strobe; qualified by cs.
- wdata  in  16  write data.
- rdata  out  16  read data, registered.
- wdt_irq  out  1  early-warning interrupt, level.
- wdt_reset_out  out  1  CPU reset request, high for PULSE_LEN cycles.

## Operation
- **CTRL fields:** [0] EN; [1] LOCK, sticky and cleared only by reset_n; [3:2] PS, prescale divider 1/16/256/4096 for codes 0..3; [6:4] PL, pulse length = PL+1 cycles. Bits [15:7] read as 0.
- **Lock:** while LOCK=1, writes to CTRL and RELOAD are ignored. KICK still works.
- **Prescaler:** a 12-bit prescale counter produces `tick` every divider cycles. It is cleared on every counter reload.
- **COUNT:** a 16-bit down-counter decremented on each tick. A RELOAD value of 0 is loaded as 1.
- **FSM states:**
  - IDLE: entered when EN=0.
  - RUN
  - WARN
  - PULSE
- **FSM transitions:**
  - IDLE→RUN on EN write 0→1; counter loads RELOAD.
  - RUN: a tick with count==1 (reaching 0) sets wdt_irq, reloads the counter, and enters WARN.
  - WARN: a tick reaching 0 enters PULSE, sets STATUS.TO and loads the pulse counter with PL.
  - PULSE: wdt_reset_out=1. When the pulse counter reaches 0, the FSM goes to RUN, reloads the counter, clears wdt_irq, and drops wdt_reset_out.
  - Any state except PULSE → IDLE on an unlocked CTRL write with EN=0. This clears wdt_irq.
- **Kick:**
  - KICK write in RUN/WARN with wdata==KICK_KEY: reload the counter, clear wdt_irq, go to RUN.
  - KICK write in RUN/WARN with any other value: immediate PULSE, and set STATUS.BK.
  - KICK writes in IDLE or PULSE are ignored.
- **STATUS read:** [1:0] state (IDLE=0, RUN=1, WARN=2, PULSE=3); [2] irq; [3] TO; [4] BK; others 0. TO and BK are sticky until reset_n; they survive PULSE.
- **Writes during PULSE:** all writes are ignored.

## Timing
- **Reset values:**
  - rdata=0, wdt_irq=0, wdt_reset_out=0.
  - CTRL=0, RELOAD=RELOAD_RST, COUNT=RELOAD_RST.
  - State IDLE; TO=BK=0; prescaler=0.
- **Read latency:** rdata is valid 1 cycle after cs&rd_en and holds until the next read.
- **Write latency:** a write in cycle N is visible in state/registers at edge N+1.
- **Timeout latency:** from a reload to wdt_irq is RELOAD×divider cycles. The WARN phase lasts another RELOAD×divider cycles before wdt_reset_out rises.
- **Outputs:** wdt_irq and wdt_reset_out are registered and glitch-free. wdt_reset_out is high for exactly PL+1 consecutive cycles.
- **Simultaneous events:**
  - A valid kick in the same cycle as the tick that would expire wins: no irq and no PULSE.
  - A bad-key kick coinciding with a tick still enters PULSE, counted once.
- **Async reset:** reset_n asserted mid-PULSE drops wdt_reset_out immediately, asynchronously.

## Test plan
- **Reset defaults:** assert reset_n=0, then release → COUNT reads 16'hFFFF, STATUS reads 0, both outputs 0.
- **Early warning and reset pulse:** RELOAD=4, CTRL=0x0001 (PS=0, PL=0) → wdt_irq rises 4 cycles after the enable edge. wdt_reset_out is high for exactly 1 cycle 4 cycles later. STATUS then reads TO=1, state RUN.
- **Valid kick in WARN:** RELOAD=8, PS=1 (÷16). Let irq assert, then write KICK=16'h5A5A → irq clears next cycle, state=RUN, COUNT=8. With kicks every 100 cycles, no pulse ever occurs.
- **Bad key:** write KICK=16'h1234 in RUN with PL=3 → wdt_reset_out is high for 4 cycles starting the next cycle. BK=1 and TO=0.
- **Lock:** CTRL=0x0003 then write CTRL=0x0000 and RELOAD=2 → EN stays 1 and RELOAD stays unchanged. reset_n clears LOCK.
- **Kick/expiry race:** force a valid kick in the exact cycle count goes 1→0 in WARN → no pulse; COUNT reloads. Also, assert reset_n mid-PULSE → output drops without waiting for a clock edge.
